// File: rtl/data_end_checker.sv
// data_end_checker: monitors bus data-phase termination timing.
// Each rising edge of data_phase opens an attempt that has to be closed by a qualifying termination fall inside a fixed age window.
`default_nettype none

module data_end_checker #(
    parameter int NUM_TERM = 2,
    parameter int MIN_DLY  = 1,
    parameter int MAX_DLY  = 5,
    parameter bit OVERLAP  = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                clr_cnt,
    input  logic                data_phase,
    input  logic                irdy,
    input  logic [NUM_TERM-1:0] term,
    output logic                pass_o,
    output logic                fail_o,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic                pending_o
);

    // npass counts ages 0..MAX_DLY, so it can never exceed MAX_DLY+1
    localparam int NP_W  = $clog2(MAX_DLY + 2);
    localparam int SUM_W = ((CNT_W > NP_W) ? CNT_W : NP_W) + 1;

    logic                primed_q;
    logic                dp_q;
    logic [NUM_TERM-1:0] term_q;
    logic [MAX_DLY:1]    pend_q;
    logic                pass_q;
    logic                fail_q;
    logic                pending_q;
    logic [CNT_W-1:0]    pass_cnt_q;
    logic [CNT_W-1:0]    fail_cnt_q;

    logic                rose;
    logic [NUM_TERM-1:0] fell;
    logic                match;
    logic                start_now;
    logic [MAX_DLY:0]    live;
    logic [MAX_DLY:0]    sat;
    logic [MAX_DLY:1]    pend_d;
    logic [NP_W-1:0]     npass;
    logic                fail;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [NP_W-1:0]  b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    // Edges are suppressed until the history registers hold a real sample
    assign rose      = primed_q & data_phase & ~dp_q;
    assign fell      = {NUM_TERM{primed_q}} & ~term & term_q;
    assign match     = primed_q & en & ~irdy & (|fell);
    assign start_now = rose & en & (OVERLAP | ~(|pend_q));

    always_comb begin
        live    = '0;
        sat     = '0;
        pend_d  = '0;
        npass   = '0;
        live[0] = start_now;
        for (int k = 1; k <= MAX_DLY; k++) begin
            live[k] = pend_q[k] & en;
        end
        for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
            sat[k] = live[k] & match;
        end
        for (int k = 0; k <= MAX_DLY; k++) begin
            npass = npass + NP_W'(sat[k]);
        end
        // Unresolved attempts age by one; the oldest age always retires
        for (int k = 0; k < MAX_DLY; k++) begin
            pend_d[k+1] = live[k] & ~sat[k];
        end
    end

    assign fail = live[MAX_DLY] & ~sat[MAX_DLY];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            primed_q   <= 1'b0;
            dp_q       <= 1'b0;
            term_q     <= '0;
            pend_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pending_q  <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            primed_q  <= 1'b1;
            dp_q      <= data_phase;
            term_q    <= term;
            pend_q    <= pend_d;
            pass_q    <= (npass != '0);
            fail_q    <= fail;
            pending_q <= |pend_d;
            if (clr_cnt) begin
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
            end else begin
                pass_cnt_q <= sat_add(pass_cnt_q, npass);
                fail_cnt_q <= sat_add(fail_cnt_q, NP_W'(fail));
            end
        end
    end

    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign pending_o = pending_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_data_end_checker.sv
// tb_data_end_checker: directed checks of data_end_checker in three parameter sets.
`default_nettype none

module tb_data_end_checker;

    logic       mclk;
    logic       rst_n;
    logic       en;
    logic       clr_cnt;
    logic       data_phase;
    logic       irdy;
    logic [1:0] term;

    logic        d_pass, d_fail, d_pend;
    logic [15:0] d_pcnt, d_fcnt;
    logic        o_pass, o_fail, o_pend;
    logic [15:0] o_pcnt, o_fcnt;
    logic        s_pass, s_fail, s_pend;
    logic [1:0]  s_pcnt, s_fcnt;

    int n_checks;
    int n_fail;
    logic saw;

    data_end_checker u_def (
        .mclk(mclk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .data_phase(data_phase), .irdy(irdy), .term(term),
        .pass_o(d_pass), .fail_o(d_fail), .pass_cnt(d_pcnt),
        .fail_cnt(d_fcnt), .pending_o(d_pend)
    );

    data_end_checker #(.MIN_DLY(2), .MAX_DLY(3), .OVERLAP(1'b0)) u_ov0 (
        .mclk(mclk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .data_phase(data_phase), .irdy(irdy), .term(term),
        .pass_o(o_pass), .fail_o(o_fail), .pass_cnt(o_pcnt),
        .fail_cnt(o_fcnt), .pending_o(o_pend)
    );

    data_end_checker #(.CNT_W(2)) u_sat (
        .mclk(mclk), .rst_n(rst_n), .en(en), .clr_cnt(clr_cnt),
        .data_phase(data_phase), .irdy(irdy), .term(term),
        .pass_o(s_pass), .fail_o(s_fail), .pass_cnt(s_pcnt),
        .fail_cnt(s_fcnt), .pending_o(s_pend)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Reset all instances, then let the priming edge pass with idle inputs
    task automatic do_reset();
        data_phase = 1'b0;
        irdy       = 1'b1;
        term       = 2'b11;
        en         = 1'b1;
        clr_cnt    = 1'b0;
        rst_n      = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset values
        do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_def_pass", {31'd0, d_pass}, 0);
        check("rst_def_fail", {31'd0, d_fail}, 0);
        check("rst_def_pend", {31'd0, d_pend}, 0);
        check("rst_def_pcnt", {16'd0, d_pcnt}, 0);
        check("rst_def_fcnt", {16'd0, d_fcnt}, 0);
        check("rst_ov0_pass", {31'd0, o_pass}, 0);
        check("rst_ov0_fail", {31'd0, o_fail}, 0);
        check("rst_sat_pass", {31'd0, s_pass}, 0);
        check("rst_sat_fcnt", {30'd0, s_fcnt}, 0);
        check("rst_sat_pend", {31'd0, s_pend}, 0);

        // Single attempt, match at age 3
        do_reset();
        data_phase = 1'b1;
        tick();
        check("t1_pend_start", {31'd0, d_pend}, 1);
        tick();
        tick();
        irdy = 1'b0;
        term = 2'b10;
        tick();
        check("t1_pass_o", {31'd0, d_pass}, 1);
        check("t1_pcnt", {16'd0, d_pcnt}, 1);
        check("t1_pend_done", {31'd0, d_pend}, 0);
        irdy = 1'b1;
        term = 2'b11;
        saw  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw = saw | d_fail;
        end
        check("t1_no_fail", {31'd0, saw}, 0);
        check("t1_pass_drop", {31'd0, d_pass}, 0);

        // Unmatched attempt expires at age 5
        do_reset();
        data_phase = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("t2_fail_early", {31'd0, d_fail}, 0);
        tick();
        check("t2_fail_o", {31'd0, d_fail}, 1);
        check("t2_fcnt", {16'd0, d_fcnt}, 1);
        check("t2_pcnt", {16'd0, d_pcnt}, 0);
        tick();
        check("t2_fail_drop", {31'd0, d_fail}, 0);

        // Two overlapping attempts satisfied by one match
        do_reset();
        data_phase = 1'b1;
        tick();
        data_phase = 1'b0;
        tick();
        data_phase = 1'b1;
        tick();
        tick();
        irdy = 1'b0;
        term = 2'b01;
        tick();
        check("t3_pass_o", {31'd0, d_pass}, 1);
        check("t3_pcnt", {16'd0, d_pcnt}, 2);
        check("t3_pend", {31'd0, d_pend}, 0);
        irdy = 1'b1;
        term = 2'b11;
        tick();
        check("t3_single_pulse", {31'd0, d_pass}, 0);

        // Termination fall with irdy high does not qualify
        do_reset();
        data_phase = 1'b1;
        tick();
        tick();
        term = 2'b10;
        tick();
        check("t4_no_pass", {31'd0, d_pass}, 0);
        term = 2'b11;
        tick();
        tick();
        check("t4_fail_early", {31'd0, d_fail}, 0);
        tick();
        check("t4_fail_o", {31'd0, d_fail}, 1);
        check("t4_pcnt", {16'd0, d_pcnt}, 0);

        // OVERLAP=0, window [2:3]: early match ignored, second rise ignored
        do_reset();
        data_phase = 1'b1;
        tick();
        data_phase = 1'b0;
        irdy = 1'b0;
        term = 2'b10;
        tick();
        check("t5_early_match", {31'd0, o_pass}, 0);
        data_phase = 1'b1;
        irdy = 1'b1;
        term = 2'b11;
        tick();
        tick();
        check("t5_fail_o", {31'd0, o_fail}, 1);
        check("t5_fcnt", {16'd0, o_fcnt}, 1);
        check("t5_pend", {31'd0, o_pend}, 0);
        check("t5_pcnt", {16'd0, o_pcnt}, 0);
        saw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw = saw | o_fail;
        end
        check("t5_no_second_fail", {31'd0, saw}, 0);

        // CNT_W=2: five fails saturate at 3
        do_reset();
        for (int i = 0; i < 14; i++) begin
            data_phase = (i < 10) && (i % 2 == 0);
            tick();
        end
        check("t6_sat_fcnt", {30'd0, s_fcnt}, 3);
        check("t6_sat_pcnt", {30'd0, s_pcnt}, 0);

        // Clear wins over a same-cycle fail
        data_phase = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("t6_clr_fail_o", {31'd0, s_fail}, 1);
        check("t6_clr_fcnt", {30'd0, s_fcnt}, 0);

        // en low mid-attempt flushes it
        data_phase = 1'b0;
        tick();
        data_phase = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        check("t6_en_flush_pend", {31'd0, s_pend}, 0);
        en  = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            saw = saw | s_fail;
        end
        check("t6_en_no_fail", {31'd0, saw}, 0);
        check("t6_en_fcnt", {30'd0, s_fcnt}, 0);

        // Reset mid-attempt discards it
        data_phase = 1'b0;
        tick();
        data_phase = 1'b1;
        tick();
        tick();
        check("t6_pend_before_rst", {31'd0, s_pend}, 1);
        rst_n = 1'b0;
        #3;
        check("t6_rst_pend", {31'd0, s_pend}, 0);
        check("t6_rst_fail", {31'd0, s_fail}, 0);
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            saw = saw | s_fail;
        end
        check("t6_rst_no_fail", {31'd0, saw}, 0);
        check("t6_rst_fcnt", {30'd0, s_fcnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
